// File: rtl/yinteg_pkg.sv
// yinteg_pkg: shared types, sizing helpers and part arithmetic
// for the Y-matrix read-modify-write engine.
package yinteg_pkg;

  localparam int IDX_W    = 16;
  localparam int PART_MAX = 64;

  typedef logic signed [PART_MAX-1:0] part_t;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    FWD,
    WR
  } state_t;

  // Parts are held sign-extended so one record type fits any REAL_W.
  typedef struct packed {
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
    part_t            re;
    part_t            im;
    logic             last;
  } chgRec_t;

  function automatic int elemW(input int realW);
    return 2 * realW;
  endfunction

  function automatic int recW(input int realW);
    return 2 * IDX_W + 2 * realW + 1;
  endfunction

  // Operands are sign-extended w-bit values; result likewise.
  function automatic part_t sat_add(
    input part_t a,
    input part_t b,
    input logic  sat,
    input int    w
  );
    logic signed [PART_MAX:0] s;
    logic signed [PART_MAX:0] hi;
    logic signed [PART_MAX:0] lo;
    part_t t;
    s  = {a[PART_MAX-1], a} + {b[PART_MAX-1], b};
    hi = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo = -(65'sd1 <<< (w - 1));
    if (sat && (s > hi)) begin
      t = hi[PART_MAX-1:0];
    end else if (sat && (s < lo)) begin
      t = lo[PART_MAX-1:0];
    end else begin
      t = part_t'(s[PART_MAX-1:0] << (PART_MAX - w)) >>> (PART_MAX - w);
    end
    return t;
  endfunction

endpackage

// File: rtl/yinteg_chg_fifo.sv
// yinteg_chg_fifo: synchronous FIFO of packed change records
// with wrap-bit pointers for full/empty detection.
module yinteg_chg_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         pushEn,
  input  logic [W-1:0] pushData,
  input  logic         popEn,
  output logic [W-1:0] popData,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]  wrPtr;
  logic [PW:0]  rdPtr;
  logic [W-1:0] store [DEPTH];

  assign empty   = (wrPtr == rdPtr);
  assign full    = (wrPtr[PW] != rdPtr[PW]) &&
                   (wrPtr[PW-1:0] == rdPtr[PW-1:0]);
  assign popData = store[rdPtr[PW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (pushEn && !full) wrPtr <= wrPtr + (PW+1)'(1);
      if (popEn && !empty) rdPtr <= rdPtr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (pushEn && !full) store[wrPtr[PW-1:0]] <= pushData;
  end

endmodule

// File: rtl/yinteg_rmw_engine.sv
// yinteg_rmw_engine: buffers admittance change records and applies
// each as a complex add into one packed Y-memory row.
module yinteg_rmw_engine
  import yinteg_pkg::*;
#(
  parameter int N_ROWS     = 16,
  parameter int N_COLS     = 16,
  parameter int REAL_W     = 24,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int SAT        = 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           chg_valid,
  output logic                           chg_ready,
  input  logic [15:0]                    chg_row,
  input  logic [15:0]                    chg_col,
  input  logic [REAL_W-1:0]              chg_real,
  input  logic [REAL_W-1:0]              chg_img,
  input  logic                           chg_last,
  output logic                           mem_rd_en,
  output logic [ADDR_W-1:0]              mem_rd_addr,
  input  logic [N_COLS*2*REAL_W-1:0]     mem_rd_data,
  output logic                           mem_wr_en,
  output logic [ADDR_W-1:0]              mem_wr_addr,
  output logic [N_COLS*2*REAL_W-1:0]     mem_wr_data,
  output logic                           upd_done,
  output logic                           batch_done,
  output logic                           err_range,
  output logic [2*REAL_W-1:0]            op_yval,
  output logic [15:0]                    upd_count
);

  localparam int   EW     = elemW(REAL_W);
  localparam int   ROW_W  = N_COLS * EW;
  localparam int   REC_W  = recW(REAL_W);
  localparam logic SAT_ON = (SAT != 0);

  state_t state;
  state_t nxt;
  chgRec_t cur;
  chgRec_t head;

  logic [REC_W-1:0] pushRec;
  logic [REC_W-1:0] headRec;
  logic full;
  logic empty;
  logic pop;
  logic oor;
  logic hit;
  logic holdVld;
  logic [IDX_W-1:0] holdRow;
  logic [ROW_W-1:0] rowReg;
  logic [ROW_W-1:0] baseRow;
  logic [ROW_W-1:0] newRow;
  logic [EW-1:0] oldEl;
  logic [EW-1:0] newEl;
  logic [EW-1:0] yval;
  logic [15:0] cnt;
  logic signed [REAL_W-1:0] oRe;
  logic signed [REAL_W-1:0] oIm;
  logic signed [REAL_W-1:0] sRe;
  logic signed [REAL_W-1:0] sIm;

  assign chg_ready = !reset && !full;
  assign pushRec   = {chg_row, chg_col, chg_real, chg_img, chg_last};

  yinteg_chg_fifo #(
    .W     (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .clock    (clock),
    .reset    (reset),
    .pushEn   (chg_valid && chg_ready),
    .pushData (pushRec),
    .popEn    (pop),
    .popData  (headRec),
    .full     (full),
    .empty    (empty)
  );

  always_comb begin
    head.row  = headRec[REC_W-1 -: IDX_W];
    head.col  = headRec[REC_W-1-IDX_W -: IDX_W];
    head.re   = part_t'($signed(headRec[2*REAL_W -: REAL_W]));
    head.im   = part_t'($signed(headRec[REAL_W -: REAL_W]));
    head.last = headRec[0];
  end

  assign oor = (32'(head.row) >= 32'(N_ROWS)) ||
               (32'(head.col) >= 32'(N_COLS));
  assign hit = holdVld && (head.row == holdRow);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt        = state;
    pop        = 1'b0;
    err_range  = 1'b0;
    batch_done = 1'b0;
    mem_rd_en  = 1'b0;
    mem_wr_en  = 1'b0;
    upd_done   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (oor) begin
            err_range  = 1'b1;
            batch_done = head.last;
          end else begin
            nxt = hit ? FWD : RD;
          end
        end
      end
      RD: begin
        mem_rd_en = 1'b1;
        nxt       = CAP;
      end
      CAP: nxt = WR;
      FWD: nxt = WR;
      WR: begin
        mem_wr_en  = 1'b1;
        upd_done   = 1'b1;
        batch_done = cur.last;
        nxt        = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // CAP merges into fresh read data; FWD merges into the held row.
  always_comb begin
    baseRow = (state == CAP) ? mem_rd_data : rowReg;
    oldEl   = baseRow[cur.col*EW +: EW];
    oRe     = oldEl[EW-1 -: REAL_W];
    oIm     = oldEl[REAL_W-1:0];
    sRe     = REAL_W'(sat_add(part_t'(oRe), cur.re, SAT_ON, REAL_W));
    sIm     = REAL_W'(sat_add(part_t'(oIm), cur.im, SAT_ON, REAL_W));
    newEl   = {sRe, sIm};
    newRow  = baseRow;
    newRow[cur.col*EW +: EW] = newEl;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur     <= '0;
      holdVld <= 1'b0;
      holdRow <= '0;
      rowReg  <= '0;
      yval    <= '0;
      cnt     <= '0;
    end else begin
      if (pop && !oor) cur <= head;
      if (pop && oor) holdVld <= 1'b0;
      if ((state == CAP) || (state == FWD)) rowReg <= newRow;
      if (state == WR) begin
        cnt     <= cnt + 16'd1;
        yval    <= rowReg[cur.col*EW +: EW];
        holdVld <= 1'b1;
        holdRow <= cur.row;
      end
    end
  end

  assign mem_rd_addr = cur.row[ADDR_W-1:0];
  assign mem_wr_addr = cur.row[ADDR_W-1:0];
  assign mem_wr_data = rowReg;
  assign op_yval     = yval;
  assign upd_count   = cnt;

endmodule

// File: tb/tb_yinteg_rmw_engine.sv
// tb_yinteg_rmw_engine: directed bench for the RMW engine, with one
// saturating and one wrapping instance sharing the change stream.
module tb_yinteg_rmw_engine;

  localparam int RW   = 24;
  localparam int NC   = 16;
  localparam int EW   = 2 * RW;
  localparam int ROWW = NC * EW;
  localparam int AW   = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic          chgValid = 1'b0;
  logic          chgLast  = 1'b0;
  logic [15:0]   chgRow   = '0;
  logic [15:0]   chgCol   = '0;
  logic [RW-1:0] chgRe    = '0;
  logic [RW-1:0] chgIm    = '0;

  logic rdyA, rdEnA, wrEnA, updA, batA, errA;
  logic rdyB, rdEnB, wrEnB, updB, batB, errB;
  logic [AW-1:0] rdAddrA, wrAddrA, rdAddrB, wrAddrB;
  logic [ROWW-1:0] rdDataA, wrDataA, rdDataB, wrDataB;
  logic [EW-1:0] yvalA, yvalB;
  logic [15:0] cntA, cntB;

  logic [ROWW-1:0] memA [256];
  logic [ROWW-1:0] memB [256];
  logic            ldEn   = 1'b0;
  logic [AW-1:0]   ldAddr = '0;
  logic [ROWW-1:0] ldData = '0;

  int vecs = 0;
  int errs = 0;
  int rdCnt = 0, wrCnt = 0, errCnt = 0, updCnt = 0;
  int batCnt = 0, batWr = 0, clash = 0, evB = 0;

  yinteg_rmw_engine #(
    .N_ROWS(16), .N_COLS(NC), .REAL_W(RW), .ADDR_W(AW),
    .FIFO_DEPTH(4), .SAT(1)
  ) dutA (
    .clock(clock), .reset(reset),
    .chg_valid(chgValid), .chg_ready(rdyA),
    .chg_row(chgRow), .chg_col(chgCol),
    .chg_real(chgRe), .chg_img(chgIm), .chg_last(chgLast),
    .mem_rd_en(rdEnA), .mem_rd_addr(rdAddrA), .mem_rd_data(rdDataA),
    .mem_wr_en(wrEnA), .mem_wr_addr(wrAddrA), .mem_wr_data(wrDataA),
    .upd_done(updA), .batch_done(batA), .err_range(errA),
    .op_yval(yvalA), .upd_count(cntA)
  );

  yinteg_rmw_engine #(
    .N_ROWS(16), .N_COLS(NC), .REAL_W(RW), .ADDR_W(AW),
    .FIFO_DEPTH(4), .SAT(0)
  ) dutB (
    .clock(clock), .reset(reset),
    .chg_valid(chgValid), .chg_ready(rdyB),
    .chg_row(chgRow), .chg_col(chgCol),
    .chg_real(chgRe), .chg_img(chgIm), .chg_last(chgLast),
    .mem_rd_en(rdEnB), .mem_rd_addr(rdAddrB), .mem_rd_data(rdDataB),
    .mem_wr_en(wrEnB), .mem_wr_addr(wrAddrB), .mem_wr_data(wrDataB),
    .upd_done(updB), .batch_done(batB), .err_range(errB),
    .op_yval(yvalB), .upd_count(cntB)
  );

  always @(posedge clock) begin
    if (ldEn) begin
      memA[ldAddr] <= ldData;
      memB[ldAddr] <= ldData;
    end
    if (wrEnA) memA[wrAddrA] <= wrDataA;
    if (wrEnB) memB[wrAddrB] <= wrDataB;
    if (rdEnA) rdDataA <= memA[rdAddrA];
    if (rdEnB) rdDataB <= memB[rdAddrB];
  end

  always @(posedge clock) begin
    rdCnt  <= rdCnt + int'(rdEnA);
    wrCnt  <= wrCnt + int'(wrEnA);
    errCnt <= errCnt + int'(errA);
    updCnt <= updCnt + int'(updA);
    batCnt <= batCnt + int'(batA);
    batWr  <= batWr + int'(batA && wrEnA);
    clash  <= clash + int'(rdEnA && wrEnA) + int'(rdEnB && wrEnB);
    evB    <= evB + int'(updB) + int'(batB) + int'(errB) + int'(rdyB);
  end

  task automatic chk(input string tag, input logic [ROWW-1:0] obs,
                     input logic [ROWW-1:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ROWW-1:0] el(input logic [RW-1:0] re,
                                         input logic [RW-1:0] im,
                                         input int col);
    logic [ROWW-1:0] v;
    v = '0;
    v[col*EW +: EW] = {re, im};
    return v;
  endfunction

  task automatic load(input logic [AW-1:0] a, input logic [ROWW-1:0] d);
    ldAddr = a;
    ldData = d;
    ldEn   = 1'b1;
    @(negedge clock);
    ldEn   = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic push(input logic [15:0] r, input logic [15:0] c,
                      input logic [RW-1:0] re, input logic [RW-1:0] im,
                      input logic l);
    int n;
    n = 0;
    chgRow = r; chgCol = c; chgRe = re; chgIm = im; chgLast = l;
    chgValid = 1'b1;
    while (!rdyA && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("push_ready", rdyA, 1);
    @(posedge clock);
    @(negedge clock);
    chgValid = 1'b0;
  endtask

  initial begin
    int r0, w0, e0, u0, b0, bw0;
    logic [ROWW-1:0] exp;

    repeat (2) @(negedge clock);
    chk("rst_ready", rdyA, 0);
    chk("rst_cnt", cntA, 0);
    chk("rst_yval", yvalA, 0);
    chk("rst_strobes", {rdEnA, wrEnA, updA, batA, errA}, 0);
    for (int i = 0; i < 16; i++) load(AW'(i), '0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", rdyA, 1);
    @(negedge clock);

    e0 = errCnt; r0 = rdCnt; w0 = wrCnt;
    push(0, 16, 24'h1, 24'h1, 1'b0);
    repeat (4) @(negedge clock);
    chk("oor_err", errCnt - e0, 1);
    chk("oor_nomem", (rdCnt - r0) + (wrCnt - w0), 0);

    push(0, 15, 24'h4ebd90, 24'h5c2e27, 1'b0);
    @(negedge clock);
    chk("fresh_rd", rdEnA, 1);
    @(negedge clock);
    chk("fresh_cap_nowr", wrEnA, 0);
    @(negedge clock);
    chk("fresh_wr", {wrEnA, updA}, 2'b11);
    chk("fresh_wr_addr", wrAddrA, 0);
    exp = el(24'h4ebd90, 24'h5c2e27, 15);
    chk("fresh_wr_data", wrDataA, exp);
    @(negedge clock);
    chk("fresh_yval", yvalA, 48'h4ebd905c2e27);
    chk("fresh_cnt", cntA, 1);
    chk("fresh_mem", memA[0], exp);

    r0 = rdCnt; w0 = wrCnt;
    push(2, 0, 24'h1, 24'hffffff, 1'b0);
    push(2, 1, 24'h1, 24'hffffff, 1'b0);
    push(2, 0, 24'h1, 24'hffffff, 1'b0);
    repeat (15) @(negedge clock);
    chk("burst_rd", rdCnt - r0, 1);
    chk("burst_wr", wrCnt - w0, 3);
    exp = el(24'h2, 24'hfffffe, 0) | el(24'h1, 24'hffffff, 1);
    chk("burst_row", memA[2], exp);
    chk("burst_cnt", cntA, 4);

    load(3, el(24'h7ffff0, 24'h800010, 0));
    push(3, 0, 24'h000100, 24'hffff00, 1'b0);
    repeat (6) @(negedge clock);
    chk("sat_on", memA[3], el(24'h7fffff, 24'h800000, 0));
    chk("sat_off", memB[3], el(24'h8000f0, 24'h7fff10, 0));
    chk("sat_yval", yvalA, 48'h7fffff800000);

    push(5, 7, 24'h10, 24'h20, 1'b0);
    push(5, 0, 24'd1, 24'd0, 1'b0);
    push(5, 1, 24'd2, 24'd0, 1'b0);
    push(5, 2, 24'd3, 24'd0, 1'b0);
    chk("bp_ready3", rdyA, 1);
    push(5, 3, 24'd4, 24'd0, 1'b0);
    chk("bp_ready4", rdyA, 0);
    push(5, 4, 24'd5, 24'd0, 1'b0);
    push(5, 5, 24'd6, 24'd0, 1'b0);
    repeat (40) @(negedge clock);
    exp = el(24'h10, 24'h20, 7);
    for (int i = 0; i < 6; i++) exp = exp | el(RW'(i + 1), '0, i);
    chk("bp_row", memA[5], exp);
    chk("bp_cnt", cntA, 12);

    e0 = errCnt; u0 = updCnt; b0 = batCnt; bw0 = batWr; r0 = rdCnt;
    push(6, 0, 24'd3, 24'd4, 1'b0);
    push(6, 1, 24'd5, 24'd6, 1'b0);
    push(16, 0, 24'd1, 24'd1, 1'b0);
    push(6, 2, 24'd7, 24'd8, 1'b1);
    repeat (20) @(negedge clock);
    chk("batch_err", errCnt - e0, 1);
    chk("batch_upd", updCnt - u0, 3);
    chk("batch_done", batCnt - b0, 1);
    chk("batch_on_wr", batWr - bw0, 1);
    chk("batch_reread", rdCnt - r0, 2);
    exp = el(24'd3, 24'd4, 0) | el(24'd5, 24'd6, 1) | el(24'd7, 24'd8, 2);
    chk("batch_row", memA[6], exp);

    r0 = rdCnt; w0 = wrCnt;
    push(7, 0, 24'd1, 24'd1, 1'b0);
    push(7, 1, 24'd1, 24'd1, 1'b0);
    chk("mid_rd", rdEnA, 1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", rdyA, 0);
    chk("mid_rst_cnt", cntA, 0);
    chk("mid_rst_yval", yvalA, 0);
    chk("mid_rst_strobes", {rdEnA, wrEnA, updA, batA, errA}, 0);
    chk("mid_rst_wdata", wrDataA, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    chk("rst_nowr", wrCnt - w0, 0);
    chk("rst_fifo_empty", rdCnt - r0, 1);
    chk("rst_ready_back", rdyA, 1);

    r0 = rdCnt;
    push(6, 0, 24'd1, 24'd1, 1'b0);
    repeat (6) @(negedge clock);
    chk("rst_reread", rdCnt - r0, 1);
    exp = el(24'd4, 24'd5, 0) | el(24'd5, 24'd6, 1) | el(24'd7, 24'd8, 2);
    chk("rst_row", memA[6], exp);
    chk("rst_cnt_after", cntA, 1);
    chk("b_cnt_after", cntB, 1);
    chk("b_active", evB > 0, 1);
    chk("no_rd_wr_clash", clash, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/yinteg_rmw_engine.md
Name: yinteg_rmw_engine

Overview:
- Parametrised successor to the single-change Y-matrix integrator.
- Accepts a stream of admittance change records (row, col, delta real, delta imag) through a valid/ready handshake and buffers them in an internal FIFO.
- For each record, performs a read-modify-write on one packed Y-memory row: adds the complex delta into the addressed element, with optional saturation.
- Forwards the held row on back-to-back same-row changes, and reports per-update and per-batch completion to the datapath controller.

Parameters:
- N_ROWS, 16, number of Y-matrix rows held in memory.
- N_COLS, 16, complex elements per memory row.
- REAL_W, 24, width of the real part and of the imaginary part (two's complement); element width EW = 2*REAL_W.
- ADDR_W, 8, memory row address width; requires N_ROWS <= 2**ADDR_W.
- FIFO_DEPTH, 4, change-record buffer depth (power of two, >= 2).
- SAT, 1, 1 = saturating add per part; 0 = two's-complement wrap.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- chg_valid  in  1  change record valid
- chg_ready  out  1  FIFO not full
- chg_row  in  16  target row index
- chg_col  in  16  target column index
- chg_real  in  REAL_W  delta real part
- chg_img  in  REAL_W  delta imaginary part
- chg_last  in  1  record closes a batch
- mem_rd_en  out  1  row read strobe; data is returned one cycle later
- mem_rd_addr  out  ADDR_W  read row address
- mem_rd_data  in  N_COLS*EW  row read data
- mem_wr_en  out  1  row write strobe
- mem_wr_addr  out  ADDR_W  write row address
- mem_wr_data  out  N_COLS*EW  updated row
- upd_done  out  1  one-cycle pulse per completed write
- batch_done  out  1  one-cycle pulse when the chg_last record retires
- err_range  out  1  one-cycle pulse when a record is dropped as out of range
- op_yval  out  EW  last updated element {real, imag}
- upd_count  out  16  number of successful updates since reset (wraps)

Behaviour:
- Packing: element k = row[k*EW +: EW]; real part in the upper REAL_W bits, imaginary part in the lower REAL_W bits.
- Handshake: a record is pushed when chg_valid && chg_ready. chg_ready = !full.
  - A push and a pop in the same cycle while the FIFO is full is not accepted (ready is already low).
- FSM states: IDLE, RD, CAP, FWD, WR.
  - IDLE: if the FIFO is non-empty, pop the head into the current-record registers.
    - Out of range (row >= N_ROWS or col >= N_COLS): pulse err_range, set hold_vld = 0, pulse batch_done if the record has last set, stay in IDLE. No memory access occurs.
    - hold_vld && row == hold_row: go to FWD.
    - Otherwise: go to RD.
  - RD: mem_rd_en = 1, mem_rd_addr = row. Go to CAP.
  - CAP: capture mem_rd_data into row_reg with element col replaced by old + delta. Go to WR.
  - FWD: apply the same add to row_reg in place; no read is issued. Go to WR.
  - WR: mem_wr_en = 1, mem_wr_addr = row, mem_wr_data = row_reg. Also in this cycle:
    - pulse upd_done;
    - increment upd_count;
    - set op_yval = the new element;
    - set hold_vld = 1, hold_row = row;
    - pulse batch_done if the record has last set.
    - Go to IDLE.
- Latency per update, from the IDLE pop to the WR cycle: 3 cycles for a fresh row, 2 cycles for a forwarded row. Minimum pop interval is 4 cycles (fresh row) or 3 cycles (forwarded row).
- Arithmetic: real and imaginary parts are added independently at REAL_W+1 bits.
  - SAT=1: clamp to [-2**(REAL_W-1), 2**(REAL_W-1)-1].
  - SAT=0: truncate.
  - Other elements of the row pass through unchanged.
- Forwarding is valid because this block is the sole writer. hold_vld clears on reset and on a dropped record.
- FIFO pointers are ADDR-free, log2(FIFO_DEPTH)+1 bits, and wrap naturally.
- Reset values, including reset asserted mid-operation:
  - every output is 0 (chg_ready is 0 during reset, 1 immediately after);
  - the FIFO is emptied;
  - the FSM returns to IDLE;
  - hold_vld = 0;
  - any in-flight record is discarded and no write is issued.
- mem_rd_en and mem_wr_en are never asserted in the same cycle.

Decomposition:
- Package yinteg_pkg holds:
  - element/row width constants and localparams derived from the parameters;
  - the FSM state enum;
  - the change-record struct {row, col, real, img, last};
  - the function sat_add(a, b, sat).
- One sub-module: yinteg_chg_fifo, a parametrised synchronous FIFO of change records with full/empty flags.

Test Plan:
- Single change: memory row 0 col 16 -> out of range for N_COLS=16, so err_range pulses once and no memory strobe occurs. Then row 0 col 15 with real=24'h4ebd90, img=24'h5c2e27 onto a zero row -> after 3 cycles, one write to addr 0 with element 15 = 48'h4ebd905c2e27, all other elements unchanged, op_yval equal to that value, upd_count = 1.
- Same-row burst: 3 records to row 2, cols 0/1/0, each real=1, img=-1 -> exactly one mem_rd_en and three mem_wr_en. Final col0 = {+2, -2}, col1 = {+1, -1}.
- Saturation: element real = 24'h7FFFF0, delta real = 24'h000100 -> with SAT=1 the result is 24'h7FFFFF; with SAT=0 it is 24'h8000F0.
- Backpressure: push 6 records back-to-back with FIFO_DEPTH=4 -> chg_ready drops after the 4th accepted push (no pop happens in the first cycle). All 6 records are eventually applied in order, and upd_count = 6.
- Batch: 4 records with the last flag on the 4th, the 3rd out of range -> exactly one err_range pulse, three upd_done pulses, and one batch_done coincident with the 4th record's WR cycle.
- Reset mid-operation: assert reset during the CAP state -> no write is issued, all outputs are 0, the FIFO is empty, and the next record after deassertion re-reads memory rather than forwarding.
